// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: the operand is split into STAGES slices, one slice
// is added per clock and the carry is registered between stages.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic             v_q  [STAGES];
  logic             c_q  [STAGES];
  logic [WIDTH-1:0] a_q  [STAGES];
  logic [WIDTH-1:0] b_q  [STAGES];
  logic [WIDTH-1:0] s_q  [STAGES];

  logic             iv   [STAGES];
  logic             ic   [STAGES];
  logic             nc   [STAGES];
  logic [WIDTH-1:0] ia   [STAGES];
  logic [WIDTH-1:0] ib   [STAGES];
  logic [WIDTH-1:0] isum [STAGES];
  logic [WIDTH-1:0] ns   [STAGES];
  logic [SW:0]      part;
  logic             adv;

  // The whole pipeline advances together, so a stalled sink freezes every stage.
  assign adv       = !v_q[LAST] | out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &
                     (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

  // Stage 0 takes the raw operands (b pre-inverted for subtract); later stages
  // take the previous stage's registers and fill in their own slice.
  always_comb begin
    iv[0]   = in_valid;
    ia[0]   = a;
    ib[0]   = sub ? ~b : b;
    ic[0]   = sub | cin;
    isum[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      iv[k]   = v_q[k-1];
      ia[k]   = a_q[k-1];
      ib[k]   = b_q[k-1];
      ic[k]   = c_q[k-1];
      isum[k] = s_q[k-1];
    end
    part = '0;
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, ia[k][k*SW +: SW]} + {1'b0, ib[k][k*SW +: SW]} + {{SW{1'b0}}, ic[k]};
      ns[k]              = isum[k];
      ns[k][k*SW +: SW]  = part[SW-1:0];
      nc[k]              = part[SW];
    end
  end

  // Data registers load only with a valid beat, so bubbles leave results untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= iv[k];
        if (iv[k]) begin
          a_q[k] <= ia[k];
          b_q[k] <= ib[k];
          s_q[k] <= ns[k];
          c_q[k] <= nc[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=32, STAGES=4): directed corner
// cases, stall, mid-flight reset and a long randomised run.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int          errors = 0;
  int          checks = 0;
  logic [33:0] exp_q[$];
  bit          rand_gap = 1'b0;
  bit          rand_ready = 1'b0;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Packs {cout, ovf, sum} from a 33-bit reference addition.
  function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mcin, input logic msub);
    logic [31:0] bb;
    logic [32:0] r;
    logic        ov;
    bb = msub ? ~mb : mb;
    r  = {1'b0, ma} + {1'b0, bb} + {32'd0, (msub ? 1'b1 : mcin)};
    ov = (ma[31] == bb[31]) && (r[31] != ma[31]);
    return {r[32], ov, r[31:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Offers one beat until accepted; the expected result joins the scoreboard
  // on the same negedge that commits the handshake.
  task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb,
                               input logic tcin, input logic tsub,
                               input logic [33:0] texp);
    bit done;
    if (rand_gap && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(texp);
        done = 1'b1;
      end
    end
    if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic measureLatency(input string tag);
    int lat;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput(tag, 64'(lat), 64'd4);
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard side: every completed output handshake is compared in order.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) checkOutput("unexpected_beat", {30'd0, cout, ovf, sum}, 64'hx);
      else checkOutput("result", {30'd0, cout, ovf, sum}, {30'd0, exp_q.pop_front()});
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rc, rs;

    // Reset state
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_sum", 64'(sum), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Carry out of the MSB, with latency check
    applyStimulus(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, {1'b1, 1'b0, 32'h0000_0000});
    measureLatency("latency_first");
    waitDrain("drain_t1");

    // Slice-boundary carry, signed overflow, subtract
    applyStimulus(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, {1'b0, 1'b0, 32'h0001_0000});
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h8000_0000});
    applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
    waitDrain("drain_t3");

    // Back-to-back beats with a 3-cycle sink stall mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
          applyStimulus(ra, rb, rc, 1'b0, model(ra, rb, rc, 1'b0));
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    waitDrain("drain_t4");

    // Asynchronous reset with three beats in flight
    out_ready = 1'b0;
    applyStimulus(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, model(32'h1111, 32'h2222, 1'b0, 1'b0));
    applyStimulus(32'h0000_3333, 32'h0000_4444, 1'b0, 1'b0, model(32'h3333, 32'h4444, 1'b0, 1'b0));
    applyStimulus(32'h0000_5555, 32'h0000_6666, 1'b0, 1'b0, model(32'h5555, 32'h6666, 1'b0, 1'b0));
    @(posedge clk); #3;
    checkOutput("pre_rst_out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("async_rst_sum", 64'(sum), 64'd0);
    checkOutput("async_rst_cout", 64'(cout), 64'd0);
    exp_q.delete();
    out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
    applyStimulus(32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b0, {1'b0, 1'b0, 32'hDEAD_BEEF});
    measureLatency("latency_after_reset");
    waitDrain("drain_t5");

    // Long randomised run with random source gaps and sink back-pressure
    rand_gap = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 16 == 0) rb = ~ra;
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    waitDrain("drain_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
